// File: rtl/fetch_defs_pkg.sv
// Shared definitions for the instruction-fetch stage: widths, reset PC,
// NOP encoding, FSM state encoding and the IF/ID register layout.
package fetch_defs;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [ILEN-1:0] NOP              = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP          = 32'd4;

    typedef enum logic {
        FETCH  = 1'b0,
        SQUASH = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [ILEN-1:0] instruction;
        logic [XLEN-1:0] pc_plus4;
        logic            valid;
    } ifid_t;

endpackage

// File: rtl/branch_fetch_stage_next_pc_select.sv
// Next-PC priority mux with the branch, jump and register target generators.
// Priority: JumpReg > Jump > BranchTaken > sequential; stall is handled by the caller.
module next_pc_select
    import fetch_defs::*;
(
    input  logic [XLEN-1:0] pc_plus4,
    input  logic [XLEN-1:0] ifid_pc_plus4,
    input  logic [XLEN-1:0] shifted_offset,
    input  logic [25:0]     jump_index,
    input  logic [XLEN-1:0] reg_target,
    input  logic            redirect_en,
    input  logic            jump_reg,
    input  logic            jump,
    input  logic            branch_taken,
    output logic [XLEN-1:0] next_pc,
    output logic            redirect
);

    logic [XLEN-1:0] branch_target;
    logic [XLEN-1:0] jump_target;
    logic [XLEN-1:0] reg_jump_target;

    assign branch_target   = ifid_pc_plus4 + shifted_offset;
    assign jump_target     = {ifid_pc_plus4[31:28], jump_index, 2'b00};
    assign reg_jump_target = reg_target & ~32'd3;

    // NOTE: every output gets a default first so no path through the mux infers a latch.
    always_comb begin
        next_pc  = pc_plus4;
        redirect = 1'b0;
        if (redirect_en) begin
            if (jump_reg) begin
                next_pc  = reg_jump_target;
                redirect = 1'b1;
            end else if (jump) begin
                next_pc  = jump_target;
                redirect = 1'b1;
            end else if (branch_taken) begin
                next_pc  = branch_target;
                redirect = 1'b1;
            end
        end
    end

endmodule

// File: rtl/branch_fetch_stage.sv
// Fetch stage: PC register, IF/ID pipeline register and FETCH/SQUASH tracker.
// Define BRANCH_DELAY_SLOT_EN to keep the delay-slot instruction instead of inserting a bubble.
module branch_fetch_stage
    import fetch_defs::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] shifted_offset,
    input  logic            jump,
    input  logic [25:0]     jump_index,
    input  logic            jump_reg,
    input  logic [XLEN-1:0] reg_target,
    output logic [XLEN-1:0] imem_addr,
    input  logic [ILEN-1:0] imem_data,
    output logic [ILEN-1:0] ifid_instruction,
    output logic [XLEN-1:0] ifid_pc_plus4,
    output logic            ifid_valid
);

`ifdef BRANCH_DELAY_SLOT_EN
    localparam bit DELAY_SLOT = 1'b1;
`else
    localparam bit DELAY_SLOT = 1'b0;
`endif

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] next_pc;
    logic            redirect;
    ifid_t           ifid;
    fetch_state_t    state;

    assign pc_plus4  = pc + PC_STEP;
    assign imem_addr = pc;

    assign ifid_instruction = ifid.instruction;
    assign ifid_pc_plus4    = ifid.pc_plus4;
    assign ifid_valid       = ifid.valid;

    next_pc_select u_next_pc_select (
        .pc_plus4       (pc_plus4),
        .ifid_pc_plus4  (ifid.pc_plus4),
        .shifted_offset (shifted_offset),
        .jump_index     (jump_index),
        .reg_target     (reg_target),
        .redirect_en    (ifid.valid & ~stall),
        .jump_reg       (jump_reg),
        .jump           (jump),
        .branch_taken   (branch_taken),
        .next_pc        (next_pc),
        .redirect       (redirect)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= RESET_PC;
            ifid  <= '{instruction: NOP, pc_plus4: '0, valid: 1'b0};
            state <= FETCH;
        end else if (!stall) begin
            pc            <= next_pc;
            ifid.pc_plus4 <= pc_plus4;
            // Wrong-path word becomes a bubble unless it is an architectural delay slot.
            if (redirect && !DELAY_SLOT) begin
                ifid.instruction <= NOP;
                ifid.valid       <= 1'b0;
            end else begin
                ifid.instruction <= imem_data;
                ifid.valid       <= 1'b1;
            end
            // SQUASH only marks that the delay slot was captured; it lasts one advancing edge.
            case (state)
                FETCH:   state <= (redirect && DELAY_SLOT) ? SQUASH : FETCH;
                SQUASH:  state <= FETCH;
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_fetch_stage.sv
// Self-checking bench for branch_fetch_stage: directed vectors with literal
// expectations plus a per-cycle comparison against a behavioural fetch model.
module tb_branch_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [31:0] shifted_offset;
    logic        jump;
    logic [25:0] jump_index;
    logic        jump_reg;
    logic [31:0] reg_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] ifid_instruction;
    logic [31:0] ifid_pc_plus4;
    logic        ifid_valid;

    int n_checks = 0;
    int n_fail   = 0;

    branch_fetch_stage dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall            (stall),
        .branch_taken     (branch_taken),
        .shifted_offset   (shifted_offset),
        .jump             (jump),
        .jump_index       (jump_index),
        .jump_reg         (jump_reg),
        .reg_target       (reg_target),
        .imem_addr        (imem_addr),
        .imem_data        (imem_data),
        .ifid_instruction (ifid_instruction),
        .ifid_pc_plus4    (ifid_pc_plus4),
        .ifid_valid       (ifid_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: every address holds a distinct, easily recognised word.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return addr ^ 32'hA5A5_0000;
    endfunction

    assign imem_data = mem_word(imem_addr);

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Behavioural model of the fetch stage.
    logic [31:0] m_pc, m_ins, m_pc4;
    logic        m_v;
    logic [31:0] m_target;
    logic        m_redirect;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc  = 32'h0;
            m_ins = 32'h0;
            m_pc4 = 32'h0;
            m_v   = 1'b0;
        end else if (!stall) begin
            m_redirect = m_v && (jump_reg || jump || branch_taken);
            if (m_v && jump_reg)
                m_target = {reg_target[31:2], 2'b00};
            else if (m_v && jump)
                m_target = {m_pc4[31:28], jump_index, 2'b00};
            else if (m_v && branch_taken)
                m_target = m_pc4 + shifted_offset;
            else
                m_target = m_pc + 32'd4;
`ifdef BRANCH_DELAY_SLOT_EN
            m_ins = mem_word(m_pc);
            m_v   = 1'b1;
`else
            m_ins = m_redirect ? 32'h0 : mem_word(m_pc);
            m_v   = !m_redirect;
`endif
            m_pc4 = m_pc + 32'd4;
            m_pc  = m_target;
        end
    end

    // Compare process: every falling edge, DUT against model.
    always @(negedge clk) begin
        check("model_addr",  imem_addr,        m_pc);
        check("model_ins",   ifid_instruction, m_ins);
        check("model_pc4",   ifid_pc_plus4,    m_pc4);
        check("model_valid", {31'b0, ifid_valid}, {31'b0, m_v});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctrl();
        stall = 0; branch_taken = 0; jump = 0; jump_reg = 0;
    endtask

    initial begin
        rst_n = 0; clear_ctrl();
        shifted_offset = 0; jump_index = 0; reg_target = 0;
        #2;
        check("rst_addr",  imem_addr, 32'h0);
        check("rst_ins",   ifid_instruction, 32'h0);
        check("rst_pc4",   ifid_pc_plus4, 32'h0);
        check("rst_valid", {31'b0, ifid_valid}, 32'h0);
        #6 rst_n = 1;

        // Sequential fetch out of reset.
        step();
        check("seq1_addr",  imem_addr, 32'h4);
        check("seq1_ins",   ifid_instruction, 32'hA5A5_0000);
        check("seq1_pc4",   ifid_pc_plus4, 32'h4);
        check("seq1_valid", {31'b0, ifid_valid}, 32'h1);
        step();
        check("seq2_addr", imem_addr, 32'h8);
        step(); step();
        check("pre_br_pc4", ifid_pc_plus4, 32'h10);

        // Backward branch from IF/ID PC+4 = 0x10 by -8.
        branch_taken = 1; shifted_offset = 32'hFFFF_FFF8;
        step();
        branch_taken = 0;
        check("br_addr", imem_addr, 32'h8);
        check("br_pc4",  ifid_pc_plus4, 32'h14);
`ifdef BRANCH_DELAY_SLOT_EN
        check("br_ins",   ifid_instruction, 32'hA5A5_0010);
        check("br_valid", {31'b0, ifid_valid}, 32'h1);
`else
        check("br_ins",   ifid_instruction, 32'h0);
        check("br_valid", {31'b0, ifid_valid}, 32'h0);
`endif
        step();
        check("br_tgt_ins", ifid_instruction, 32'hA5A5_0008);

        // Move to 0x4000000C so IF/ID PC+4 becomes 0x40000010, then jump.
        jump_reg = 1; reg_target = 32'h4000_000C;
        step();
        jump_reg = 0;
        step();
        check("pre_j_pc4", ifid_pc_plus4, 32'h4000_0010);
        jump = 1; jump_index = 26'h000_0100;
        step();
        jump = 0;
        check("j_addr", imem_addr, 32'h4000_0400);
        step();

        // Register jump clears the low two bits.
        jump_reg = 1; reg_target = 32'h0000_1237;
        step();
        jump_reg = 0;
        check("jr_addr", imem_addr, 32'h0000_1234);
        step();
        check("pre_stall_pc4", ifid_pc_plus4, 32'h0000_1238);

        // Three stalled edges with a pending branch: nothing moves.
        stall = 1; branch_taken = 1; shifted_offset = 32'h100;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_addr", imem_addr, 32'h0000_1238);
            check("stall_pc4",  ifid_pc_plus4, 32'h0000_1238);
            check("stall_ins",  ifid_instruction, 32'hA5A5_1234);
        end
        stall = 0;
        step();
        branch_taken = 0;
        check("post_stall_addr", imem_addr, 32'h0000_1338);

        // Asynchronous reset in the middle of a cycle with a branch pending.
        step();
        branch_taken = 1;
        #3 rst_n = 0;
        #1;
        check("async_addr",  imem_addr, 32'h0);
        check("async_ins",   ifid_instruction, 32'h0);
        check("async_valid", {31'b0, ifid_valid}, 32'h0);
        branch_taken = 0;
        #2 rst_n = 1;
        step();
        check("rel_addr", imem_addr, 32'h4);

        // Sequential wrap from the top of the address space.
        jump_reg = 1; reg_target = 32'hFFFF_FFFF;
        step();
        jump_reg = 0;
        check("top_addr", imem_addr, 32'hFFFF_FFFC);
        step();
        check("wrap_addr", imem_addr, 32'h0);
        check("wrap_pc4",  ifid_pc_plus4, 32'h0);
        check("wrap_ins",  ifid_instruction, 32'h5A5A_FFFC);
        step();

        @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
